// File: rtl/core_ctrl_fsm_if.sv
// Control/datapath/memory handshake bundle for the RV32I multi-cycle sequencer.
// master = the sequencer, slave = decoder, datapath and memory ports.
interface core_ctrl_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       br_taken;
    logic       imem_ack;
    logic       dmem_ack;

    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [2:0] imm_sel;
    logic [1:0] alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] alu_op;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       retire;
    logic       trap;

    modport master (
        input  opcode, funct3, rd, br_taken, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, imm_sel,
               alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, retire, trap
    );

    modport slave (
        output opcode, funct3, rd, br_taken, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, imm_sel,
               alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, retire, trap
    );
endinterface

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky
// illegal-opcode TRAP and a wrapping retired-instruction counter.
module core_ctrl_fsm #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    core_ctrl_fsm_if.master     bus,
    output logic [RETIRE_W-1:0] retire_cnt
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_RS1   = 2'd2;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_FUNC = 2'd1;
    localparam logic [1:0] ALU_CMP  = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [RETIRE_W-1:0] retire_cnt_q, retire_cnt_d;

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic is_load, is_store, is_opimm, is_op, is_legal;

    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, retire, trap;
    logic [1:0] pc_sel, alu_a_sel, alu_op, wb_sel;
    logic [2:0] imm_sel;
    logic       alu_b_sel;

    logic [2:0] imm_fmt;
    logic [1:0] exec_a_sel, exec_op;
    logic       exec_b_sel;

    // funct3 only matters to the datapath (load/store width, branch compare)
    logic unused_funct3;
    assign unused_funct3 = ^bus.funct3;

    always_comb begin
        is_lui    = (bus.opcode == OPC_LUI);
        is_auipc  = (bus.opcode == OPC_AUIPC);
        is_jal    = (bus.opcode == OPC_JAL);
        is_jalr   = (bus.opcode == OPC_JALR);
        is_branch = (bus.opcode == OPC_BRANCH);
        is_load   = (bus.opcode == OPC_LOAD);
        is_store  = (bus.opcode == OPC_STORE);
        is_opimm  = (bus.opcode == OPC_OPIMM);
        is_op     = (bus.opcode == OPC_OP);
        is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                    is_load | is_store | is_opimm | is_op;
    end

    always_comb begin
        imm_fmt = IMM_I;
        if (is_lui || is_auipc) imm_fmt = IMM_U;
        else if (is_jal)        imm_fmt = IMM_J;
        else if (is_branch)     imm_fmt = IMM_B;
        else if (is_store)      imm_fmt = IMM_S;
    end

    // ALU selects are held from EXEC through WB so address and result stay stable
    always_comb begin
        exec_a_sel = A_RS1;
        exec_b_sel = 1'b1;
        exec_op    = ALU_ADD;
        if (is_lui)                 exec_a_sel = A_ZERO;
        else if (is_auipc || is_jal) exec_a_sel = A_PC;
        if (is_op || is_branch)     exec_b_sel = 1'b0;
        if (is_op || is_opimm)      exec_op = ALU_FUNC;
        else if (is_branch)         exec_op = ALU_CMP;
    end

    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        imm_sel   = IMM_I;
        alu_a_sel = A_RS1;
        alu_b_sel = 1'b0;
        alu_op    = ALU_ADD;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        retire    = 1'b0;
        trap      = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                imm_sel = imm_fmt;
                state_d = is_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                imm_sel   = imm_fmt;
                alu_a_sel = exec_a_sel;
                alu_b_sel = exec_b_sel;
                alu_op    = exec_op;
                if (is_branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = bus.br_taken ? PC_IMM : PC_PLUS4;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                imm_sel   = imm_fmt;
                alu_a_sel = exec_a_sel;
                alu_b_sel = exec_b_sel;
                alu_op    = exec_op;
                dmem_req  = 1'b1;
                dmem_we   = is_store;
                if (bus.dmem_ack) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                imm_sel   = imm_fmt;
                alu_a_sel = exec_a_sel;
                alu_b_sel = exec_b_sel;
                alu_op    = exec_op;
                pc_we     = 1'b1;
                retire    = 1'b1;
                rf_we     = (bus.rd != 5'd0);
                if (is_load)                wb_sel = WB_MEM;
                else if (is_jal || is_jalr) wb_sel = WB_PC4;
                if (is_jal)                 pc_sel = PC_IMM;
                else if (is_jalr)           pc_sel = PC_RS1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset aborts the current instruction immediately: no request, write or retire
        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            rf_we    = 1'b0;
            retire   = 1'b0;
        end
    end

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (retire) retire_cnt_d = retire_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign bus.imem_req  = imem_req;
    assign bus.dmem_req  = dmem_req;
    assign bus.dmem_we   = dmem_we;
    assign bus.ir_we     = ir_we;
    assign bus.pc_we     = pc_we;
    assign bus.pc_sel    = pc_sel;
    assign bus.imm_sel   = imm_sel;
    assign bus.alu_a_sel = alu_a_sel;
    assign bus.alu_b_sel = alu_b_sel;
    assign bus.alu_op    = alu_op;
    assign bus.rf_we     = rf_we;
    assign bus.wb_sel    = wb_sel;
    assign bus.retire    = retire;
    assign bus.trap      = trap;
    assign retire_cnt    = retire_cnt_q;

endmodule
